// File: rtl/sms_card_rst_seq.sv
// Staggered multi-channel power-on reset sequencer with a restart trigger.
// Define SMS_RST_TRIG_SYNC_EN to pass trig through a two-flop synchronizer before use.
module sms_card_rst_seq #(
    parameter int unsigned CHANNELS       = 4,
    parameter int unsigned HOLD_CYCLES    = 20,
    parameter int unsigned STAGGER_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                trig,
    output logic [CHANNELS-1:0] a,
    output logic [CHANNELS-1:0] b,
    output logic                done
);

    localparam int unsigned MAX_CYC = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES
                                                                      : STAGGER_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
    localparam int unsigned IDX_W   = $clog2(CHANNELS) + 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(CHANNELS - 1);

    localparam logic [1:0] StHold    = 2'd0;
    localparam logic [1:0] StStagger = 2'd1;
    localparam logic [1:0] StRun     = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CHANNELS-1:0] a_q, a_d;
    logic                done_q, done_d;
    logic                trig_eff;

`ifdef SMS_RST_TRIG_SYNC_EN
    logic trig_meta_q, trig_sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trig_meta_q <= 1'b0;
            trig_sync_q <= 1'b0;
        end else begin
            trig_meta_q <= trig;
            trig_sync_q <= trig_meta_q;
        end
    end

    assign trig_eff = trig_sync_q;
`else
    assign trig_eff = trig;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        a_d     = a_q;
        done_d  = done_q;
        if (trig_eff) begin
            // Restart behaves exactly like a system reset.
            state_d = StHold;
            cnt_d   = '0;
            idx_d   = '0;
            a_d     = '0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                StHold: begin
                    if (cnt_q == HOLD_LAST) begin
                        a_d[0] = 1'b1;
                        cnt_d  = '0;
                        if (CHANNELS == 1) begin
                            done_d  = 1'b1;
                            state_d = StRun;
                        end else begin
                            idx_d   = IDX_W'(1);
                            state_d = StStagger;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StStagger: begin
                    if (cnt_q == STAG_LAST) begin
                        for (int i = 0; i < int'(CHANNELS); i++) begin
                            if (idx_q == IDX_W'(i)) a_d[i] = 1'b1;
                        end
                        cnt_d = '0;
                        idx_d = idx_q + 1'b1;
                        if (idx_q == IDX_LAST) begin
                            done_d  = 1'b1;
                            state_d = StRun;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StRun: begin
                end
                default: begin
                    // Unreachable encoding: recover by restarting the sequence.
                    state_d = StHold;
                    cnt_d   = '0;
                    idx_d   = '0;
                    a_d     = '0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StHold;
            cnt_q   <= '0;
            idx_q   <= '0;
            a_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            done_q  <= done_d;
        end
    end

    assign a    = a_q;
    assign b    = ~a_q;
    assign done = done_q;

endmodule
